rx_deserializer: RTL and testbench
==================================

RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 SHALL have parameter wordSize, default 8, number of data bits per frame.
REQ-002 SHALL have parameter sizeBitCount, default 3, width of bit counter minus one (counter is sizeBitCount+1 bits).
REQ-003 SHALL have parameter overSample, default 8, sampleTick pulses per bit period (power of two, >=4).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sampleTick  input  1  one-cycle enable at overSample x baud rate.
REQ-007 SHALL have port serialIn  input  1  line from transmitter, idle high.
REQ-008 SHALL have port readRequest  input  1  host acknowledges/consumes rcvData.
REQ-009 SHALL have port rcvData  output  wordSize  last received word.
REQ-010 SHALL have port readNotReady  output  1  high while unread word is held in rcvData.
REQ-011 SHALL have port errorStop  output  1  framing error, stop bit sampled low.
REQ-012 SHALL have port errorOverrun  output  1  new word completed while readNotReady high.
REQ-013 SHALL have port errorParity  output  1  parity mismatch (see Configuration).

Function
REQ-014 SHALL implement states IDLE, STARTING, RECEIVING; all state changes except reset and readRequest effects occur only on cycles with sampleTick=1.
REQ-015 IDLE: serialIn=0 on a tick -> STARTING, sample counter cleared.
REQ-016 STARTING: count ticks; at tick overSample/2-1, serialIn=0 -> RECEIVING (counters cleared); serialIn=1 -> IDLE (glitch rejected, no flags change).
REQ-017 RECEIVING: sample serialIn every overSample ticks (bit centre); shift into shiftReg MSB side, right-shifting, so data is LSB-first.
REQ-018 After wordSize data samples (plus parity sample if enabled), next sample is stop bit; frame completes on that tick and FSM -> IDLE same tick.
REQ-019 On completion: rcvData <= shiftReg data, readNotReady <= 1, errorStop <= (stop sample==0), all on the completion tick.
REQ-020 Completion with readNotReady=1 and readRequest=0: errorOverrun <= 1, rcvData SHALL be overwritten with new word.
REQ-021 readRequest=1: readNotReady <= 0 next cycle; errorStop, errorOverrun, errorParity cleared next cycle.
REQ-022 Simultaneous readRequest and completion: completion wins -- readNotReady=1, new data and new error flags, no overrun.
REQ-023 Latency: rcvData/readNotReady valid 1 clk after the tick sampling stop bit.
REQ-024 Stop bit sampled low SHALL NOT hang FSM; receiver returns to IDLE and re-arms on next low.
REQ-025 Bit counter SHALL not wrap within a frame; widths sized so wordSize+2 fits in sizeBitCount+1 bits.

Reset
REQ-026 rst=1 at a clk edge: state IDLE, counters 0, shiftReg 0, rcvData 0, readNotReady 0, all error flags 0; overrides every other input, including mid-frame (partial frame discarded).

Configuration
REQ-027 Macro RX_PARITY_EN defined: one even-parity bit expected after data bits, before stop; errorParity <= (XOR of data and parity bit != 0) at completion.
REQ-028 RX_PARITY_EN undefined: frame is start+wordSize+stop, errorParity port present and tied 0.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE, STARTING, RECEIVING) and default wordSize/overSample constants, shared with the transmit side.
REQ-030 One sub-module rx_sample_timer SHALL implement tick counting and emit bit-centre strobe; FSM, shift and flag logic stay in rx_deserializer.

Verification
REQ-031 Frame 0xA5 (LSB first, stop=1), overSample=8 -> rcvData=0xA5, readNotReady=1, all errors 0.
REQ-032 Low pulse of 2 ticks in IDLE -> FSM returns IDLE, readNotReady stays 0.
REQ-033 Frame 0x3C with stop bit 0 -> rcvData=0x3C, errorStop=1; next valid frame 0x01 after readRequest -> errorStop=0.
REQ-034 Two frames 0x11 then 0x22 without readRequest -> rcvData=0x22, errorOverrun=1; readRequest clears both flags.
REQ-035 rst asserted at data bit 4 of frame 0xFF -> all outputs 0, following frame 0x5A received correctly.
REQ-036 With RX_PARITY_EN: 0x07 with parity bit 0 -> errorParity=1; parity bit 1 -> errorParity=0.

Source files
------------

// File: rtl/rx_deserializer_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// also used by the transmit side.
package rx_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STARTING  = 2'd1,
        RECEIVING = 2'd2
    } rxState_t;

    localparam int DEFAULT_WORD_SIZE   = 8;
    localparam int DEFAULT_OVER_SAMPLE = 8;

    // Samples taken after the start bit: data bits, optional parity bit, stop bit.
    function automatic int frameSamples(input int wordSize, input bit parityEn);
        return wordSize + (parityEn ? 1 : 0) + 1;
    endfunction

endpackage

// File: rtl/rx_sample_timer.sv
// Oversample tick counter for the receiver: flags the start-bit midpoint and
// the centre of every following bit period.
module rx_sample_timer
    import rx_deserializer_pkg::*;
#(
    parameter int overSample = DEFAULT_OVER_SAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic sampleTick,
    input  logic clear,
    output logic midStrobe,
    output logic bitStrobe
);

    localparam int tickW = $clog2(overSample);
    localparam logic [tickW-1:0] midCount  = tickW'(overSample / 2 - 1);
    localparam logic [tickW-1:0] lastCount = tickW'(overSample - 1);

    logic [tickW-1:0] tickCount;

    // Tick counter; overSample is a power of two so it wraps once per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tickCount <= '0;
        end else if (clear) begin
            tickCount <= '0;
        end else if (sampleTick) begin
            tickCount <= tickCount + tickW'(1);
        end else begin
            tickCount <= tickCount;
        end
    end

    assign midStrobe = sampleTick && (tickCount == midCount);
    assign bitStrobe = sampleTick && (tickCount == lastCount);

endmodule

// File: rtl/rx_deserializer.sv
// UART receive deserializer: start detection, LSB-first shifting, framing,
// overrun and optional even-parity checking (enabled by macro RX_PARITY_EN).
module rx_deserializer
    import rx_deserializer_pkg::*;
#(
    parameter int wordSize     = DEFAULT_WORD_SIZE,
    parameter int sizeBitCount = 3,
    parameter int overSample   = DEFAULT_OVER_SAMPLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sampleTick,
    input  logic                serialIn,
    input  logic                readRequest,
    output logic [wordSize-1:0] rcvData,
    output logic                readNotReady,
    output logic                errorStop,
    output logic                errorOverrun,
    output logic                errorParity
);

`ifdef RX_PARITY_EN
    localparam bit parityEn = 1'b1;
    localparam logic [sizeBitCount:0] parityIndex = (sizeBitCount + 1)'(wordSize);
`else
    localparam bit parityEn = 1'b0;
`endif
    localparam int bitCntW = sizeBitCount + 1;
    localparam logic [bitCntW-1:0] stopIndex = bitCntW'(frameSamples(wordSize, parityEn) - 1);
    localparam logic [bitCntW-1:0] dataCount = bitCntW'(wordSize);

    rxState_t            state;
    rxState_t            nextState;
    logic [bitCntW-1:0]  bitCount;
    logic [wordSize-1:0] shiftReg;
    logic                timerClear;
    logic                sampleStrobe;
    logic                frameDone;
    logic                midStrobe;
    logic                bitStrobe;

`ifdef RX_PARITY_EN
    logic parityBit;

    function automatic logic parityError(input logic [wordSize-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction
`endif

    rx_sample_timer #(
        .overSample(overSample)
    ) sampleTimer (
        .clk       (clk),
        .rst       (rst),
        .sampleTick(sampleTick),
        .clear     (timerClear),
        .midStrobe (midStrobe),
        .bitStrobe (bitStrobe)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; every transition is qualified by a sample tick.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (sampleTick && !serialIn) begin
                    nextState = STARTING;
                end else begin
                    nextState = IDLE;
                end
            end
            STARTING: begin
                if (midStrobe) begin
                    nextState = serialIn ? IDLE : RECEIVING;
                end else begin
                    nextState = STARTING;
                end
            end
            RECEIVING: begin
                if (bitStrobe && (bitCount == stopIndex)) begin
                    nextState = IDLE;
                end else begin
                    nextState = RECEIVING;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: timer held clear while idle and re-phased at the start-bit midpoint.
    always_comb begin
        timerClear   = 1'b0;
        sampleStrobe = 1'b0;
        frameDone    = 1'b0;
        case (state)
            IDLE: begin
                timerClear = 1'b1;
            end
            STARTING: begin
                timerClear = midStrobe;
            end
            RECEIVING: begin
                sampleStrobe = bitStrobe;
                frameDone    = bitStrobe && (bitCount == stopIndex);
            end
            default: begin
                timerClear = 1'b1;
            end
        endcase
    end

    // Bit counter for the samples of the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitCount <= '0;
        end else if (state != RECEIVING) begin
            bitCount <= '0;
        end else if (frameDone) begin
            bitCount <= '0;
        end else if (sampleStrobe) begin
            bitCount <= bitCount + bitCntW'(1);
        end else begin
            bitCount <= bitCount;
        end
    end

    // Data shift register: new bits enter at the MSB so the first bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg <= '0;
        end else if (sampleStrobe && (bitCount < dataCount)) begin
            shiftReg <= {serialIn, shiftReg[wordSize-1:1]};
        end else begin
            shiftReg <= shiftReg;
        end
    end

`ifdef RX_PARITY_EN
    // Parity sample, taken between the last data bit and the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            parityBit <= 1'b0;
        end else if (sampleStrobe && (bitCount == parityIndex)) begin
            parityBit <= serialIn;
        end else begin
            parityBit <= parityBit;
        end
    end
`endif

    // Host-visible word and flags; a completing frame takes priority over a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcvData      <= '0;
            readNotReady <= 1'b0;
            errorStop    <= 1'b0;
            errorOverrun <= 1'b0;
            errorParity  <= 1'b0;
        end else if (frameDone) begin
            rcvData      <= shiftReg;
            readNotReady <= 1'b1;
            errorStop    <= ~serialIn;
            errorOverrun <= readNotReady & ~readRequest;
`ifdef RX_PARITY_EN
            errorParity  <= parityError(shiftReg, parityBit);
`else
            errorParity  <= 1'b0;
`endif
        end else if (readRequest) begin
            rcvData      <= rcvData;
            readNotReady <= 1'b0;
            errorStop    <= 1'b0;
            errorOverrun <= 1'b0;
            errorParity  <= 1'b0;
        end else begin
            rcvData      <= rcvData;
            readNotReady <= readNotReady;
            errorStop    <= errorStop;
            errorOverrun <= errorOverrun;
            errorParity  <= errorParity;
        end
    end

endmodule

// File: tb/tb_rx_deserializer.sv
// Randomized bench for rx_deserializer against a frame-level reference model;
// parity cases are exercised when RX_PARITY_EN is defined.
module tb_rx_deserializer;

    localparam int W  = 8;
    localparam int OS = 8;
`ifdef RX_PARITY_EN
    localparam bit parityEn = 1'b1;
`else
    localparam bit parityEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sampleTick;
    logic         serialIn;
    logic         readRequest;
    logic [W-1:0] rcvData;
    logic         readNotReady;
    logic         errorStop;
    logic         errorOverrun;
    logic         errorParity;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model of the host-visible receiver state.
    logic [W-1:0] mData;
    logic         mRnr;
    logic         mStop;
    logic         mOvr;
    logic         mPar;

    rx_deserializer #(
        .wordSize    (W),
        .sizeBitCount(3),
        .overSample  (OS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sampleTick  (sampleTick),
        .serialIn    (serialIn),
        .readRequest (readRequest),
        .rcvData     (rcvData),
        .readNotReady(readNotReady),
        .errorStop   (errorStop),
        .errorOverrun(errorOverrun),
        .errorParity (errorParity)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkValue({tag, ".data"},    32'(rcvData),      32'(mData));
        checkValue({tag, ".rnr"},     32'(readNotReady), 32'(mRnr));
        checkValue({tag, ".stop"},    32'(errorStop),    32'(mStop));
        checkValue({tag, ".overrun"}, 32'(errorOverrun), 32'(mOvr));
        checkValue({tag, ".parity"},  32'(errorParity),  32'(mPar));
    endtask

    task automatic modelReset();
        mData = '0;
        mRnr  = 1'b0;
        mStop = 1'b0;
        mOvr  = 1'b0;
        mPar  = 1'b0;
    endtask

    // One sampleTick pulse every three clocks; starts and ends just after a negedge.
    task automatic doTick();
        sampleTick = 1'b1;
        @(negedge clk);
        sampleTick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input int nTicks);
        serialIn = b;
        repeat (nTicks) doTick();
    endtask

    task automatic sendFrame(input logic [W-1:0] data, input logic stopBit, input logic parBit);
        sendBit(1'b0, OS);
        for (int i = 0; i < W; i++) sendBit(data[i], OS);
`ifdef RX_PARITY_EN
        sendBit(parBit, OS);
`endif
        sendBit(stopBit, OS);
        serialIn = 1'b1;
        if (mRnr) mOvr = 1'b1;
        mData = data;
        mRnr  = 1'b1;
        mStop = ~stopBit;
        mPar  = parityEn ? ((^data) ^ parBit) : 1'b0;
    endtask

    task automatic readWord();
        readRequest = 1'b1;
        @(negedge clk);
        readRequest = 1'b0;
        mRnr  = 1'b0;
        mStop = 1'b0;
        mOvr  = 1'b0;
        mPar  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d;
        logic         sb;
        logic         pb;
        rst         = 1'b1;
        sampleTick  = 1'b0;
        serialIn    = 1'b1;
        readRequest = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkAll("reset");

        // Nominal frame.
        sendFrame(8'hA5, 1'b1, ^8'hA5);
        sendBit(1'b1, 4);
        checkAll("a5");

        // Two-tick low glitch must not start a frame.
        readWord();
        sendBit(1'b0, 2);
        sendBit(1'b1, 10);
        checkAll("glitch");

        // Framing error, then a clean frame after the read.
        sendFrame(8'h3C, 1'b0, ^8'h3C);
        sendBit(1'b1, 4);
        checkAll("stop0");
        readWord();
        sendFrame(8'h01, 1'b1, ^8'h01);
        sendBit(1'b1, 4);
        checkAll("after_stop0");

        // Overrun: two frames without a read.
        readWord();
        sendFrame(8'h11, 1'b1, ^8'h11);
        sendBit(1'b1, 4);
        sendFrame(8'h22, 1'b1, ^8'h22);
        sendBit(1'b1, 4);
        checkAll("overrun");
        readWord();
        checkAll("overrun_read");

        // Reset in the middle of a frame discards it.
        sendFrame(8'h99, 1'b1, ^8'h99);
        sendBit(1'b1, 4);
        sendBit(1'b0, OS);
        for (int i = 0; i < 4; i++) sendBit(1'b1, OS);
        sendBit(1'b1, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        checkAll("rst_mid");
        sendBit(1'b1, 8);
        sendFrame(8'h5A, 1'b1, ^8'h5A);
        sendBit(1'b1, 4);
        checkAll("after_rst");
        readWord();

`ifdef RX_PARITY_EN
        sendFrame(8'h07, 1'b1, 1'b0);
        sendBit(1'b1, 4);
        checkAll("par_bad");
        readWord();
        sendFrame(8'h07, 1'b1, 1'b1);
        sendBit(1'b1, 4);
        checkAll("par_good");
        readWord();
`endif

        // Random frames with occasional framing/parity errors and skipped reads.
        for (int n = 0; n < 40; n++) begin
            d  = W'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            pb = (^d) ^ ($urandom_range(0, 5) == 0);
            sendFrame(d, sb, pb);
            sendBit(1'b1, $urandom_range(3, 10));
            checkAll($sformatf("rand%0d", n));
            if ($urandom_range(0, 2) != 0) begin
                readWord();
                checkValue($sformatf("rand%0d.read", n), 32'(readNotReady), 32'(mRnr));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
